ncap_level_ctrl: RTL and testbench

Next-generation NIC power-state interrupt generator.
- Measures completed RX/TX packets per programmable interval (epoch).
- Tracks one of NUM_LEVELS performance levels and decides level changes from per-level up/down thresholds, with down-hysteresis over consecutive epochs.
- Raises a level-coded interrupt to the OS driver, held until acknowledged; changes that occur before the ack are coalesced into it.
- Sits beside the MAC AXI-Stream RX/TX interfaces as a passive monitor.

---
 rtl/ncap_level_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ncap_level_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncap_level_ctrl.sv
// Packet-rate performance level controller for a NIC: counts RX/TX packets per epoch,
// steps a level up/down from per-level thresholds and reports changes on a held irq.
//
// state    | meaning
// IRQ_IDLE | no interrupt outstanding
// IRQ_PEND | irq held high until irq_ack; later changes overwrite irq_level

module ncap_level_ctrl #(
  parameter int NUM_LEVELS  = 4,
  parameter int LVL_W       = 2,
  parameter int COUNT_W     = 32,
  parameter int RESET_LEVEL = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             interval,
  input  logic [NUM_LEVELS*32-1:0] thr_up_rx,
  input  logic [NUM_LEVELS*32-1:0] thr_down_rx,
  input  logic [NUM_LEVELS*32-1:0] thr_down_tx,
  input  logic [7:0]              down_hold,
  input  logic                    aggressive_mode,
  input  logic                    rx_tvalid,
  input  logic                    rx_tready,
  input  logic                    rx_tlast,
  input  logic                    tx_tvalid,
  input  logic                    tx_tready,
  input  logic                    tx_tlast,
  input  logic                    irq_ack,
  output logic                    irq,
  output logic [LVL_W-1:0]        irq_level,
  output logic [LVL_W-1:0]        cur_level,
  output logic [COUNT_W-1:0]      epoch_rx_count,
  output logic [COUNT_W-1:0]      epoch_tx_count
);

  localparam int CMP_W = (COUNT_W > 32) ? COUNT_W : 32;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [LVL_W-1:0]   RST_LVL = LVL_W'(RESET_LEVEL);

  typedef enum logic {IRQ_IDLE, IRQ_PEND} irq_state_t;

  irq_state_t state_q, state_d;
  logic [LVL_W-1:0] irq_level_d;

  logic [31:0] tmr_q, term_q, term_in;
  logic        epoch_end;

  logic               rx_hs, tx_hs;
  logic [COUNT_W-1:0] rx_cnt_q, tx_cnt_q, rx_cnt_inc, tx_cnt_inc;

  logic [LVL_W-1:0] up_tgt;
  logic             up_ok, up_chg;
  logic [31:0]      dn_rx_thr, dn_tx_thr;
  logic             low_epoch, step_down;
  logic [7:0]       streak_q, streak_inc, hold_eff;
  logic             chg_q;

  // The top up-threshold has no level above it.
  logic unused_thr_top;
  assign unused_thr_top = ^thr_up_rx[NUM_LEVELS*32-1 -: 32];

  // Epoch length is latched at each wrap, so a new interval applies from the next epoch.
  assign term_in   = (interval == 32'd0) ? 32'd0 : interval - 32'd1;
  assign epoch_end = (tmr_q == term_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q  <= 32'd0;
      term_q <= term_in;
    end else if (epoch_end) begin
      tmr_q  <= 32'd0;
      term_q <= term_in;
    end else begin
      tmr_q  <= tmr_q + 32'd1;
    end
  end

  assign rx_hs = rx_tvalid & rx_tready & rx_tlast;
  assign tx_hs = tx_tvalid & tx_tready & tx_tlast;
  assign rx_cnt_inc = (rx_hs && rx_cnt_q != CNT_MAX) ? rx_cnt_q + COUNT_W'(1) : rx_cnt_q;
  assign tx_cnt_inc = (tx_hs && tx_cnt_q != CNT_MAX) ? tx_cnt_q + COUNT_W'(1) : tx_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_q       <= '0;
      tx_cnt_q       <= '0;
      epoch_rx_count <= '0;
      epoch_tx_count <= '0;
    end else if (epoch_end) begin
      rx_cnt_q       <= '0;
      tx_cnt_q       <= '0;
      epoch_rx_count <= rx_cnt_inc;
      epoch_tx_count <= tx_cnt_inc;
    end else begin
      rx_cnt_q       <= rx_cnt_inc;
      tx_cnt_q       <= tx_cnt_inc;
    end
  end

  // Climb while every threshold from the current level upward is exceeded.
  always_comb begin
    up_tgt = cur_level;
    up_ok  = 1'b1;
    for (int k = 0; k < NUM_LEVELS - 1; k++) begin
      if (k >= int'(cur_level)) begin
        if (up_ok && (CMP_W'(rx_cnt_inc) > CMP_W'(thr_up_rx[32*k +: 32])))
          up_tgt = LVL_W'(k + 1);
        else
          up_ok = 1'b0;
      end
    end
  end

  always_comb begin
    dn_rx_thr = 32'd0;
    dn_tx_thr = 32'd0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (LVL_W'(i) == cur_level) begin
        dn_rx_thr = thr_down_rx[32*i +: 32];
        dn_tx_thr = thr_down_tx[32*i +: 32];
      end
    end
  end

  assign up_chg     = (up_tgt != cur_level);
  assign low_epoch  = (cur_level != '0) &&
                      (CMP_W'(rx_cnt_inc) < CMP_W'(dn_rx_thr)) &&
                      (CMP_W'(tx_cnt_inc) < CMP_W'(dn_tx_thr));
  assign hold_eff   = (down_hold == 8'd0) ? 8'd1 : down_hold;
  assign streak_inc = streak_q + 8'd1;
  assign step_down  = low_epoch && (streak_inc >= hold_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_level <= RST_LVL;
      streak_q  <= 8'd0;
      chg_q     <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      if (epoch_end) begin
        if (up_chg) begin
          cur_level <= up_tgt;
          streak_q  <= 8'd0;
          chg_q     <= 1'b1;
        end else if (step_down) begin
          cur_level <= cur_level - LVL_W'(1);
          streak_q  <= 8'd0;
          chg_q     <= ~aggressive_mode;
        end else if (low_epoch) begin
          streak_q  <= streak_inc;
        end else begin
          streak_q  <= 8'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IRQ_IDLE;
      irq_level <= RST_LVL;
    end else begin
      state_q   <= state_d;
      irq_level <= irq_level_d;
    end
  end

  // chg_q marks the decision cycle; cur_level already holds the new level there.
  always_comb begin
    state_d     = state_q;
    irq_level_d = irq_level;
    case (state_q)
      IRQ_IDLE: begin
        if (chg_q) begin
          state_d     = IRQ_PEND;
          irq_level_d = cur_level;
        end
      end
      IRQ_PEND: begin
        if (chg_q)
          irq_level_d = cur_level;
        else if (irq_ack)
          state_d = IRQ_IDLE;
      end
    endcase
  end

  assign irq = (state_q == IRQ_PEND);

endmodule

// File: tb/tb_ncap_level_ctrl.sv
// Bench for ncap_level_ctrl: epoch table, directed corner sequences and random traffic
// checked every cycle against an epoch-level reference model.
module tb_ncap_level_ctrl;

  localparam int NL = 4;
  localparam int LW = 2;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     interval;
  logic [NL*32-1:0] thr_up_rx, thr_down_rx, thr_down_tx;
  logic [7:0]      down_hold;
  logic            aggressive_mode;
  logic            rx_tvalid, rx_tready, rx_tlast;
  logic            tx_tvalid, tx_tready, tx_tlast;
  logic            irq_ack;
  logic            irq;
  logic [LW-1:0]   irq_level, cur_level;
  logic [CW-1:0]   epoch_rx_count, epoch_tx_count;

  always #5 clk = ~clk;

  ncap_level_ctrl #(.NUM_LEVELS(NL), .LVL_W(LW), .COUNT_W(CW), .RESET_LEVEL(0)) dut (
    .clk(clk), .rst(rst), .interval(interval),
    .thr_up_rx(thr_up_rx), .thr_down_rx(thr_down_rx), .thr_down_tx(thr_down_tx),
    .down_hold(down_hold), .aggressive_mode(aggressive_mode),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
    .irq_ack(irq_ack), .irq(irq), .irq_level(irq_level), .cur_level(cur_level),
    .epoch_rx_count(epoch_rx_count), .epoch_tx_count(epoch_tx_count)
  );

  int n_pass = 0;
  int n_total = 0;
  int iv;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: epoch position, packet totals, level, low-epoch run, irq state.
  longint m_pos, m_term, m_rx, m_tx, m_erx, m_etx;
  int     m_lvl, m_streak, m_irql;
  bit     m_irq, m_report;

  function automatic longint thr_of(input logic [NL*32-1:0] v, input int i);
    return longint'(v[32*i +: 32]);
  endfunction

  task automatic model_decide(input longint rx, input longint tx);
    int j;
    int hold;
    j = m_lvl;
    while (j < NL - 1 && rx > thr_of(thr_up_rx, j)) j++;
    if (j > m_lvl) begin
      m_lvl = j;
      m_streak = 0;
      m_report = 1'b1;
    end else if (m_lvl > 0 && rx < thr_of(thr_down_rx, m_lvl) && tx < thr_of(thr_down_tx, m_lvl)) begin
      m_streak++;
      hold = (down_hold == 0) ? 1 : int'(down_hold);
      if (m_streak >= hold) begin
        m_lvl--;
        m_streak = 0;
        m_report = !aggressive_mode;
      end
    end else begin
      m_streak = 0;
    end
  endtask

  task automatic model_step();
    longint rx, tx;
    if (rst) begin
      m_pos = 0; m_term = (interval == 0) ? 1 : longint'(interval);
      m_rx = 0; m_tx = 0; m_erx = 0; m_etx = 0;
      m_lvl = 0; m_streak = 0; m_irq = 1'b0; m_irql = 0; m_report = 1'b0;
      return;
    end
    if (m_report) begin
      m_irq = 1'b1;
      m_irql = m_lvl;
    end else if (irq_ack) begin
      m_irq = 1'b0;
    end
    m_report = 1'b0;
    rx = m_rx + ((rx_tvalid && rx_tready && rx_tlast) ? 1 : 0);
    tx = m_tx + ((tx_tvalid && tx_tready && tx_tlast) ? 1 : 0);
    if (rx > 64'hFFFF_FFFF) rx = 64'hFFFF_FFFF;
    if (tx > 64'hFFFF_FFFF) tx = 64'hFFFF_FFFF;
    if (m_pos == m_term - 1) begin
      m_erx = rx; m_etx = tx;
      m_rx = 0; m_tx = 0; m_pos = 0;
      m_term = (interval == 0) ? 1 : longint'(interval);
      model_decide(rx, tx);
    end else begin
      m_rx = rx; m_tx = tx; m_pos++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_irq", irq, m_irq);
    chk("model_irq_level", irq_level, m_irql);
    chk("model_cur_level", cur_level, m_lvl);
    chk("model_epoch_rx", epoch_rx_count, m_erx);
    chk("model_epoch_tx", epoch_tx_count, m_etx);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_epoch(input int n_rx, input int n_tx, input int first, input int c_start);
    for (int c = c_start; c < iv; c++) begin
      rx_tvalid = (c >= first) && (c < first + n_rx);
      tx_tvalid = (c >= first) && (c < first + n_tx);
      tick();
    end
    rx_tvalid = 1'b0;
    tx_tvalid = 1'b0;
  endtask

  typedef struct {
    int n_rx; int n_tx; int ack_at; int exp_lvl; int exp_irq; int exp_irql;
  } row_t;
  row_t tbl[17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // n_rx, n_tx, ack cycle, level after epoch, irq / irq_level one cycle later
    tbl[0]  = '{0,  0, 50, 0, 0, 0};
    tbl[1]  = '{35, 0, -1, 3, 1, 3};
    tbl[2]  = '{2,  1, 50, 3, 0, 3};
    tbl[3]  = '{2,  1, -1, 3, 0, 3};
    tbl[4]  = '{2,  1, -1, 2, 1, 2};
    tbl[5]  = '{2,  1, 50, 2, 0, 2};
    tbl[6]  = '{2,  1, -1, 2, 0, 2};
    tbl[7]  = '{6,  1, -1, 2, 0, 2};
    tbl[8]  = '{2,  1, -1, 2, 0, 2};
    tbl[9]  = '{2,  1, -1, 2, 0, 2};
    tbl[10] = '{2,  1, -1, 1, 1, 1};
    tbl[11] = '{15, 0, 50, 1, 0, 1};
    tbl[12] = '{25, 3, -1, 2, 1, 2};
    tbl[13] = '{30, 0, -1, 2, 1, 2};
    tbl[14] = '{5,  0, -1, 2, 1, 2};
    tbl[15] = '{4,  5, -1, 2, 1, 2};
    tbl[16] = '{31, 0, -1, 3, 1, 3};

    rst = 1'b1; interval = 32'd100; iv = 100;
    thr_up_rx   = {32'd99, 32'd30, 32'd20, 32'd10};
    thr_down_rx = {32'd5, 32'd5, 32'd5, 32'd0};
    thr_down_tx = {32'd5, 32'd5, 32'd5, 32'd0};
    down_hold = 8'd3; aggressive_mode = 1'b0;
    rx_tvalid = 1'b0; rx_tready = 1'b1; rx_tlast = 1'b1;
    tx_tvalid = 1'b0; tx_tready = 1'b1; tx_tlast = 1'b1;
    irq_ack = 1'b0;

    do_reset();
    chk("reset_irq", irq, 0);
    chk("reset_irq_level", irq_level, 0);
    chk("reset_cur_level", cur_level, 0);
    chk("reset_rx_count", epoch_rx_count, 0);
    chk("reset_tx_count", epoch_tx_count, 0);

    for (int r = 0; r < 17; r++) begin
      for (int c = 0; c < iv; c++) begin
        rx_tvalid = (c >= 1) && (c < 1 + tbl[r].n_rx);
        tx_tvalid = (c >= 1) && (c < 1 + tbl[r].n_tx);
        irq_ack   = (c == tbl[r].ack_at);
        tick();
        if (c == 0 && r > 0) begin
          chk($sformatf("tbl%0d_irq", r - 1), irq, tbl[r-1].exp_irq);
          chk($sformatf("tbl%0d_irq_level", r - 1), irq_level, tbl[r-1].exp_irql);
        end
      end
      rx_tvalid = 1'b0; tx_tvalid = 1'b0; irq_ack = 1'b0;
      chk($sformatf("tbl%0d_cur_level", r), cur_level, tbl[r].exp_lvl);
      chk($sformatf("tbl%0d_rx_count", r), epoch_rx_count, tbl[r].n_rx);
      chk($sformatf("tbl%0d_tx_count", r), epoch_tx_count, tbl[r].n_tx);
    end
    tick();
    chk("tbl16_irq", irq, tbl[16].exp_irq);
    chk("tbl16_irq_level", irq_level, tbl[16].exp_irql);

    // Step up, coalesce, ack racing a change, boundary packet, reset while pending.
    interval = 32'd40; iv = 40;
    do_reset();
    run_epoch(15, 0, 1, 0);
    chk("p1_cur_level", cur_level, 1);
    chk("p1_irq_early", irq, 0);
    tick();
    chk("p1_irq", irq, 1);
    chk("p1_irq_level", irq_level, 1);
    run_epoch(25, 0, 2, 1);
    chk("coal_cur_level", cur_level, 2);
    tick();
    chk("coal_irq", irq, 1);
    chk("coal_irq_level", irq_level, 2);
    run_epoch(35, 0, 2, 1);
    chk("jump_cur_level", cur_level, 3);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("ack_vs_change_irq", irq, 1);
    chk("ack_vs_change_irq_level", irq_level, 3);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("ack_clear_irq", irq, 0);
    run_epoch(1, 0, iv - 1, 2);
    chk("edge_pkt_rx_count", epoch_rx_count, 1);
    run_epoch(1, 0, 0, 0);
    chk("restart_rx_count", epoch_rx_count, 1);
    run_epoch(0, 0, 0, 0);
    chk("hold_down_level", cur_level, 2);
    tick();
    chk("down_irq", irq, 1);
    chk("down_irq_level", irq_level, 2);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_pend_irq", irq, 0);
    chk("rst_pend_cur_level", cur_level, 0);
    chk("rst_pend_irq_level", irq_level, 0);
    chk("rst_pend_rx_count", epoch_rx_count, 0);
    run_epoch(0, 0, 0, 0);
    run_epoch(0, 0, 0, 0);
    chk("post_rst_irq", irq, 0);
    chk("post_rst_cur_level", cur_level, 0);

    // Silent downward steps.
    aggressive_mode = 1'b1;
    do_reset();
    run_epoch(25, 0, 1, 0);
    chk("aggr_up_level", cur_level, 2);
    tick();
    chk("aggr_up_irq", irq, 1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("aggr_ack_irq", irq, 0);
    for (int i = 0; i < 3; i++) run_epoch(2, 1, (i == 0) ? 2 : 1, (i == 0) ? 2 : 0);
    chk("aggr_cur_level", cur_level, 1);
    tick();
    chk("aggr_irq", irq, 0);
    chk("aggr_irq_level", irq_level, 2);
    aggressive_mode = 1'b0;

    // interval 0 behaves as a one-cycle epoch.
    interval = 32'd0; iv = 1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rx_tvalid = (i % 2 == 1);
      tick();
      chk("iv0_rx_count", epoch_rx_count, (i % 2 == 1) ? 1 : 0);
    end
    rx_tvalid = 1'b0;

    // Random traffic against the model.
    for (int blk = 0; blk < 4; blk++) begin
      for (int j = 0; j < NL; j++) begin
        thr_up_rx[32*j +: 32]   = $urandom_range(0, 6);
        thr_down_rx[32*j +: 32] = $urandom_range(0, 6);
        thr_down_tx[32*j +: 32] = $urandom_range(0, 6);
      end
      down_hold = 8'($urandom_range(0, 3));
      aggressive_mode = ($urandom_range(0, 1) == 1);
      interval = $urandom_range(0, 8);
      do_reset();
      for (int n = 0; n < 1000; n++) begin
        rx_tvalid = ($urandom_range(0, 3) != 0);
        rx_tready = ($urandom_range(0, 3) != 0);
        rx_tlast  = ($urandom_range(0, 3) != 0);
        tx_tvalid = ($urandom_range(0, 3) != 0);
        tx_tready = ($urandom_range(0, 3) != 0);
        tx_tlast  = ($urandom_range(0, 3) != 0);
        irq_ack   = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 99) == 0) interval = $urandom_range(0, 8);
        if ($urandom_range(0, 199) == 0) aggressive_mode = ~aggressive_mode;
        rst = ($urandom_range(0, 499) == 0);
        tick();
      end
      rst = 1'b0; irq_ack = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
